pll_reset_seq: RTL and testbench

Reset sequencer and lock watchdog for the system PLL. Runs on the always-present board reference clock and drives the PLL's active-high reset input. It also consumes the PLL's asynchronous `locked` output. It releases the system reset only after lock has been stable for a programmed interval. On a lock timeout or lock loss, it re-initialises the PLL and counts the events.

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/sync2ff.sv | 30 +++
 rtl/pll_reset_seq.sv | 155 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_e     : sequencer states
//   LOST_CNT_W  : width of the saturating lock-loss counter
//   cnt_width() : width of the single phase counter (covers the largest interval)
package pll_seq_pkg;

  typedef enum logic [1:0] {
    S_PLLRST,
    S_WAITLOCK,
    S_STABLE,
    S_RUN
  } state_e;

  localparam int unsigned LOST_CNT_W = 8;

  // The counter only needs to reach (interval - 1), so $clog2 of the largest interval suffices.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
//   clk_i  : destination clock
//   clr_ni : asynchronous clear, active low; forces both flops to ClrVal
//   d_i    : asynchronous input
//   q_o    : synchronized output
module sync2ff #(
  parameter logic ClrVal = 1'b0
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      meta_q <= ClrVal;
      sync_q <= ClrVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer and lock watchdog, clocked by the board reference clock.
//   i_clk       : reference clock (only clock)
//   i_nrst      : asynchronous active-low reset
//   i_locked    : PLL lock, asynchronous to i_clk
//   i_reinit    : single-cycle request to re-initialise the PLL
//   o_pll_rst   : active-high PLL reset
//   o_sys_nrst  : active-low system reset, released once lock has been stable long enough
//   o_lock_lost : one-cycle pulse when lock drops in RUN
//   o_timeout   : one-cycle pulse when the lock wait expires
//   o_lost_cnt  : saturating count of lock losses in RUN
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_locked,
  input  logic                  i_reinit,
  output logic                  o_pll_rst,
  output logic                  o_sys_nrst,
  output logic                  o_lock_lost,
  output logic                  o_timeout,
  output logic [LOST_CNT_W-1:0] o_lost_cnt
);

  localparam int unsigned CntW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [LOST_CNT_W-1:0] LostMax = {LOST_CNT_W{1'b1}};

  logic rst_sync_n;
  logic locked_s;

  // Reset asserts immediately with i_nrst and releases two edges after it rises.
  sync2ff #(
    .ClrVal(1'b0)
  ) u_rst_sync (
    .clk_i (i_clk),
    .clr_ni(i_nrst),
    .d_i   (1'b1),
    .q_o   (rst_sync_n)
  );

  sync2ff #(
    .ClrVal(1'b0)
  ) u_lock_sync (
    .clk_i (i_clk),
    .clr_ni(rst_sync_n),
    .d_i   (i_locked),
    .q_o   (locked_s)
  );

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  lost_evt;
  logic                  timeout_evt;

  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_nrst_q, sys_nrst_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  timeout_q, timeout_d;
  logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_nrst_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_nrst_q  <= sys_nrst_d;
      lock_lost_q <= lock_lost_d;
      timeout_q   <= timeout_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  // Next state. Reinit outranks everything outside PLLRST; lock outranks timeout in
  // WAITLOCK; a drop outranks the terminal count in STABLE.
  always_comb begin
    state_d     = state_q;
    lost_evt    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == PllRstLast) state_d = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (i_reinit) begin
          state_d = S_PLLRST;
        end else if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = S_PLLRST;
          timeout_evt = 1'b1;
        end
      end
      S_STABLE: begin
        if (i_reinit) begin
          state_d = S_PLLRST;
        end else if (!locked_s) begin
          state_d = S_WAITLOCK;
        end else if (cnt_q == StableLast) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_reinit) begin
          state_d = S_PLLRST;
        end else if (!locked_s) begin
          state_d  = S_PLLRST;
          lost_evt = 1'b1;
        end
      end
      default: state_d = S_PLLRST;
    endcase

    // Counter restarts on every state change; RUN has no interval so it holds there.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != S_RUN) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs decoded from the next state so they move on the same edge as the state.
  always_comb begin
    pll_rst_d   = (state_d == S_PLLRST);
    sys_nrst_d  = (state_d == S_RUN);
    lock_lost_d = lost_evt;
    timeout_d   = timeout_evt;
    lost_cnt_d  = lost_cnt_q;
    if (lost_evt && (lost_cnt_q != LostMax)) lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);
  end

  assign o_pll_rst   = pll_rst_q;
  assign o_sys_nrst  = sys_nrst_q;
  assign o_lock_lost = lock_lost_q;
  assign o_timeout   = timeout_q;
  assign o_lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq. Expected event edges are derived arithmetically
// from the sequencing rules (reset sync 2 edges, lock sync 2 edges, interval lengths);
// lock-loss counting is modelled with a saturating integer.
module tb_pll_reset_seq;

  localparam int unsigned PR = 4;
  localparam int unsigned LS = 8;
  localparam int unsigned LT = 32;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       locked = 1'b0;
  logic       reinit = 1'b0;
  logic       pll_rst, sys_nrst, lock_lost, timeout;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;
  int model_lost = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .PLL_RST_CYCLES(PR),
    .LOCK_STABLE   (LS),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_locked   (locked),
    .i_reinit   (reinit),
    .o_pll_rst  (pll_rst),
    .o_sys_nrst (sys_nrst),
    .o_lock_lost(lock_lost),
    .o_timeout  (timeout),
    .o_lost_cnt (lost_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves i_nrst just released; the next posedge is edge 1.
  task automatic apply_reset(input logic lk);
    locked = lk;
    reinit = 1'b0;
    nrst   = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    model_lost = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 60 && sys_nrst !== 1'b1; i++) tick();
    checks++;
    if (sys_nrst !== 1'b1) begin
      errors++;
      $display("FAIL wait_run: o_sys_nrst got %b want 1 within 60 cycles", sys_nrst);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({pll_rst, sys_nrst, lock_lost, timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 1000", {pll_rst, sys_nrst, lock_lost, timeout});
    end
    checks++;
    if (lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_lost_cnt: got %0d want 0", lost_cnt);
    end
  endtask

  // Lock high from the start: locked_s is already 1 when WAITLOCK is entered at edge 2+PR,
  // so STABLE follows one edge later and RUN LS edges after that.
  task automatic test_powerup();
    logic exp_rst, exp_sys;
    apply_reset(1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_rst = (e < int'(2 + PR));
      exp_sys = (e >= int'(3 + PR + LS));
      checks++;
      if ({pll_rst, sys_nrst, timeout} !== {exp_rst, exp_sys, 1'b0}) begin
        errors++;
        $display("FAIL powerup edge %0d: rst/sys/to got %b want %b", e,
                 {pll_rst, sys_nrst, timeout}, {exp_rst, exp_sys, 1'b0});
      end
    end
  endtask

  // Lock raised d cycles into WAITLOCK; o_sys_nrst must rise at edge LS+2 counted from
  // the first edge sampling i_locked=1. d = LT-3 makes lock and timeout coincide.
  task automatic test_lock_acquire(input int d);
    logic exp_sys;
    apply_reset(1'b0);
    repeat (2 + PR + d) tick();
    locked = 1'b1;
    for (int k = 0; k <= int'(LS) + 4; k++) begin
      tick();
      exp_sys = (k >= int'(LS + 2));
      checks++;
      if ({pll_rst, sys_nrst, timeout} !== {1'b0, exp_sys, 1'b0}) begin
        errors++;
        $display("FAIL lock_acquire d=%0d edge %0d: rst/sys/to got %b want %b", d, k,
                 {pll_rst, sys_nrst, timeout}, {1'b0, exp_sys, 1'b0});
      end
    end
  endtask

  task automatic test_timeout();
    int   k;
    logic exp_rst, exp_to;
    apply_reset(1'b0);
    for (int e = 1; e <= int'(2 + PR + 3 * (LT + PR)); e++) begin
      tick();
      if (e < int'(2 + PR)) begin
        exp_rst = 1'b1;
        exp_to  = 1'b0;
      end else begin
        k       = (e - int'(2 + PR)) % int'(LT + PR);
        exp_rst = (k >= int'(LT));
        exp_to  = (k == int'(LT));
      end
      checks++;
      if ({pll_rst, sys_nrst, timeout} !== {exp_rst, 1'b0, exp_to}) begin
        errors++;
        $display("FAIL timeout edge %0d: rst/sys/to got %b want %b", e,
                 {pll_rst, sys_nrst, timeout}, {exp_rst, 1'b0, exp_to});
      end
    end
    checks++;
    if (lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL timeout_lost_cnt: got %0d want 0", lost_cnt);
    end
  endtask

  // STABLE entered at edge S = 2+PR+3. The drop is timed so the FSM sees locked_s=0 on
  // edge S+LS, exactly when the stable count is LS-1.
  task automatic test_stable_drop();
    logic exp_sys;
    apply_reset(1'b0);
    repeat (2 + PR) tick();
    locked = 1'b1;
    repeat (3 + LS - 3) tick();
    locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({pll_rst, sys_nrst} !== 2'b00) begin
        errors++;
        $display("FAIL stable_drop hold %0d: rst/sys got %b want 00", k, {pll_rst, sys_nrst});
      end
    end
    locked = 1'b1;
    for (int k = 0; k <= int'(LS) + 4; k++) begin
      tick();
      exp_sys = (k >= int'(LS + 2));
      checks++;
      if ({pll_rst, sys_nrst} !== {1'b0, exp_sys}) begin
        errors++;
        $display("FAIL stable_restart edge %0d: rst/sys got %b want %b", k,
                 {pll_rst, sys_nrst}, {1'b0, exp_sys});
      end
    end
  endtask

  // Must be called in RUN. drop_len is 2 or 3 cycles of i_locked low.
  task automatic lose_lock(input int drop_len);
    locked = 1'b0;
    tick();
    tick();
    checks++;
    if ({sys_nrst, pll_rst, lock_lost} !== 3'b100) begin
      errors++;
      $display("FAIL loss_edge1: sys/rst/lost got %b want 100", {sys_nrst, pll_rst, lock_lost});
    end
    if (drop_len == 2) locked = 1'b1;
    tick();
    model_lost = (model_lost >= 255) ? 255 : model_lost + 1;
    checks++;
    if ({sys_nrst, pll_rst, lock_lost} !== 3'b011) begin
      errors++;
      $display("FAIL loss_edge2: sys/rst/lost got %b want 011", {sys_nrst, pll_rst, lock_lost});
    end
    checks++;
    if (lost_cnt !== 8'(model_lost)) begin
      errors++;
      $display("FAIL loss_cnt: got %0d want %0d", lost_cnt, model_lost);
    end
    locked = 1'b1;
    tick();
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL loss_pulse_width: o_lock_lost got %b want 0", lock_lost);
    end
    wait_run();
  endtask

  task automatic test_run_loss();
    apply_reset(1'b1);
    repeat (3 + PR + LS) tick();
    checks++;
    if (sys_nrst !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: o_sys_nrst got %b want 1", sys_nrst);
    end
    lose_lock(2);
  endtask

  task automatic test_reinit();
    logic exp_rst;
    // Reinit in RUN, then a reinit during PLLRST that must not stretch the pulse.
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    checks++;
    if ({pll_rst, sys_nrst, lock_lost} !== 3'b100 || lost_cnt !== 8'(model_lost)) begin
      errors++;
      $display("FAIL reinit_run: rst/sys/lost got %b cnt %0d want 100 cnt %0d",
               {pll_rst, sys_nrst, lock_lost}, lost_cnt, model_lost);
    end
    tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    for (int e = 2; e <= int'(PR) + 1; e++) begin
      if (e > 2) tick();
      exp_rst = (e < int'(PR));
      checks++;
      if (pll_rst !== exp_rst) begin
        errors++;
        $display("FAIL reinit_ignored edge N+%0d: o_pll_rst got %b want %b", e, pll_rst, exp_rst);
      end
    end
    wait_run();
    // Reinit on the same edge the FSM would see the lock drop.
    locked = 1'b0;
    tick();
    tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    checks++;
    if ({pll_rst, sys_nrst, lock_lost} !== 3'b100 || lost_cnt !== 8'(model_lost)) begin
      errors++;
      $display("FAIL reinit_vs_loss: rst/sys/lost got %b cnt %0d want 100 cnt %0d",
               {pll_rst, sys_nrst, lock_lost}, lost_cnt, model_lost);
    end
    tick();
    checks++;
    if (lock_lost !== 1'b0 || lost_cnt !== 8'(model_lost)) begin
      errors++;
      $display("FAIL reinit_vs_loss_after: lost %b cnt %0d want 0 cnt %0d",
               lock_lost, lost_cnt, model_lost);
    end
    locked = 1'b1;
    wait_run();
  endtask

  task automatic test_saturation();
    int losses;
    losses = model_lost;
    while (losses < 300) begin
      lose_lock(int'($urandom_range(2, 3)));
      losses++;
    end
    checks++;
    if (lost_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation: o_lost_cnt got %0d want 255", lost_cnt);
    end
  endtask

  task automatic test_nrst_mid_stable();
    logic exp_rst, exp_sys;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    repeat (PR + 3) tick();
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_nrst, lock_lost, timeout} !== 4'b1000 || lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nrst_async: rst/sys/lost/to got %b cnt %0d want 1000 cnt 0",
               {pll_rst, sys_nrst, lock_lost, timeout}, lost_cnt);
    end
    tick();
    tick();
    nrst = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_rst = (e < int'(2 + PR));
      exp_sys = (e >= int'(3 + PR + LS));
      checks++;
      if ({pll_rst, sys_nrst, lost_cnt} !== {exp_rst, exp_sys, 8'd0}) begin
        errors++;
        $display("FAIL nrst_restart edge %0d: rst/sys got %b cnt %0d want %b cnt 0", e,
                 {pll_rst, sys_nrst}, lost_cnt, {exp_rst, exp_sys});
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_acquire(int'(LT) - 3);
    repeat (3) test_lock_acquire(int'($urandom_range(0, LT - 4)));
    test_timeout();
    test_stable_drop();
    test_run_loss();
    test_reinit();
    test_saturation();
    test_nrst_mid_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
